ldm_stm_seq: RTL and testbench
==============================

LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: i_rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: i_start  in  1  EX holds a valid LDM/STM this cycle.
REQ-004 SHALL have: i_reg_list  in  16  register list, bit n = Rn.
REQ-005 SHALL have: i_base  in  32  base register value; i_base_code  in  4  base register number.
REQ-006 SHALL have: i_up, i_pre, i_wb, i_load  in  1 each  U, P, W, L instruction bits.
REQ-007 SHALL have: i_flush  in  1  abort the sequence. i_mem_ready  in  1  memory stage accepts the current transfer.
REQ-008 SHALL have: o_ldm_hold  out  1  pipeline hold request to the hazard controller.
REQ-009 SHALL have: o_xfer_vld  out  1; o_xfer_addr  out  32; o_xfer_rd_code  out  4; o_xfer_load  out  1; o_xfer_last  out  1.
REQ-010 SHALL have: o_wb_vld  out  1; o_wb_code  out  4; o_wb_data  out  32  base writeback. o_busy  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, XFER, WB.
REQ-012 IDLE: i_start with a nonzero list SHALL latch the list, base, U, W, L and base code; compute n = popcount(list); go to XFER.
REQ-013 i_start with an all-zero list SHALL be ignored: no transfer, no hold, no writeback.
REQ-014 The first address SHALL be selected by U/P as follows.
- IA: base.
- IB: base+4.
- DA: base-4n+4.
- DB: base-4n.
- All arithmetic is mod 2^32.
REQ-015 Registers SHALL transfer in ascending register number at ascending addresses, +4 per transfer.
REQ-016 XFER: o_xfer_vld = 1 with o_xfer_rd_code = lowest set bit of the remaining list; o_xfer_load = latched L.
REQ-017 A transfer completes only on o_xfer_vld && i_mem_ready; the addr, rd_code and last outputs SHALL hold stable while i_mem_ready = 0.
REQ-018 On completion, the sequencer SHALL clear that bit and advance the address by 4.
REQ-019 o_xfer_last SHALL be 1 when exactly one bit remains.
REQ-020 After the last completion, the FSM SHALL go to WB if W = 1 and writeback is not suppressed; otherwise it SHALL go to IDLE.
REQ-021 Writeback value SHALL be base+4n if U = 1, base-4n if U = 0.
REQ-022 Writeback SHALL be suppressed when L = 1 and the base is in the list (the loaded value wins).
REQ-023 WB: o_wb_vld = 1 for exactly one cycle with o_wb_code = base code, then the FSM SHALL go to IDLE.
REQ-024 o_ldm_hold SHALL be combinational: 1 when (IDLE && i_start && list != 0) or the state is XFER or WB; 0 otherwise.
REQ-025 o_busy SHALL be 1 when the state is not IDLE.
REQ-026 i_flush SHALL combinationally force o_xfer_vld and o_wb_vld to 0; the FSM SHALL go to IDLE on the next edge with the list cleared.
REQ-027 i_flush SHALL take priority over i_start and over completion in the same cycle.
REQ-028 i_start while busy SHALL be ignored.
REQ-029 A 16-register list SHALL complete in 16 accepted transfers with no wrap error on the remaining-count logic.

Reset
REQ-030 On i_rst_n low the block SHALL asynchronously enter IDLE, with the latched list = 0, address = 0, and every output = 0.
REQ-031 Reset mid-sequence SHALL drop the sequence with no writeback.
REQ-032 The block SHALL resume operation on the first clock edge after i_rst_n rises.

Structure
REQ-033 FSM state encodings and the transfer step constant (4) SHALL live in the shared core definitions header.
REQ-034 A single sub-module pri_enc16 SHALL give the lowest set bit index and a zero flag of the 16-bit remaining list.
REQ-035 Popcount and address arithmetic SHALL be inline in ldm_stm_seq.

Verification
REQ-036 IA, list 0x000F, base 0x1000, W=1, L=0, ready=1 -> addresses 0x1000/04/08/0C, codes 0-3, last on the 4th transfer; wb 0x1010; hold high for 5 cycles.
REQ-037 DB, list 0x8001, base 0x2000, W=1 -> r0 at 0x1FF8, r15 at 0x1FFC; wb 0x1FF8.
REQ-038 IB, list 0x0006, ready low 3 cycles on the first transfer -> addr 0x1004 and r1 held stable for those cycles; then r2 at 0x1008.
REQ-039 LDM, list 0x0011, base code 4, W=1 -> two transfers, no o_wb_vld.
REQ-040 Flush during the 2nd of 4 transfers -> o_xfer_vld 0 that cycle, IDLE next cycle, hold 0, no wb.
REQ-041 Start with list 0x0000 -> hold, o_xfer_vld and o_wb_vld stay 0; a reset pulse mid-XFER returns all outputs to 0 immediately.

Source files
------------

// File: rtl/ldm_stm_seq_pkg.sv
// rtl/ldm_stm_seq_pkg.sv - shared core definitions for the LDM/STM sequencer
package ldm_stm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_WB   = 2'd2
    } seq_state_t;

    localparam logic [31:0] XFER_STEP = 32'd4;

endpackage

// File: rtl/ldm_stm_seq_pri_enc16.sv
// rtl/ldm_stm_seq_pri_enc16.sv - lowest-set-bit priority encoder for a 16-bit list
module pri_enc16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_zero
);

    // Scan downward so the lowest set bit is the last to win.
    always_comb begin
        o_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
    end

    assign o_zero = (i_vec == 16'd0);

endmodule

// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - block-transfer sequencer for LDM/STM with base writeback
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_reg_list,
    input  logic [31:0] i_base,
    input  logic [3:0]  i_base_code,
    input  logic        i_up,
    input  logic        i_pre,
    input  logic        i_wb,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic        i_mem_ready,
    output logic        o_ldm_hold,
    output logic        o_xfer_vld,
    output logic [31:0] o_xfer_addr,
    output logic [3:0]  o_xfer_rd_code,
    output logic        o_xfer_load,
    output logic        o_xfer_last,
    output logic        o_wb_vld,
    output logic [3:0]  o_wb_code,
    output logic [31:0] o_wb_data,
    output logic        o_busy
);

    seq_state_t  r_state;
    logic [15:0] r_list;
    logic [4:0]  r_cnt;
    logic [31:0] r_addr;
    logic        r_load;
    logic        r_wb_en;
    logic [3:0]  r_base_code;
    logic [31:0] r_wb_data;

    logic [4:0]  w_pop;
    logic [31:0] w_span;
    logic [31:0] w_first_addr;
    logic [31:0] w_wb_data;
    logic        w_wb_en;
    logic        w_start;
    logic [3:0]  w_low_idx;
    logic        w_list_zero;
    logic [15:0] w_clr_mask;

    // Five-bit count so a full 16-register list is representable.
    always_comb begin
        w_pop = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_pop = w_pop + {4'd0, i_reg_list[i]};
        end
    end

    assign w_span = 32'(w_pop) * XFER_STEP;

    // Lowest address of the block; transfers always walk upward from here.
    always_comb begin
        w_first_addr = i_base;
        case ({i_up, i_pre})
            2'b10:   w_first_addr = i_base;
            2'b11:   w_first_addr = i_base + XFER_STEP;
            2'b00:   w_first_addr = i_base - w_span + XFER_STEP;
            default: w_first_addr = i_base - w_span;
        endcase
    end

    assign w_wb_data = i_up ? (i_base + w_span) : (i_base - w_span);
    // A load that targets the base register overrides the writeback.
    assign w_wb_en   = i_wb && !(i_load && i_reg_list[i_base_code]);
    assign w_start   = (r_state == ST_IDLE) && i_start && (i_reg_list != 16'd0);

    pri_enc16 u_pri_enc16 (
        .i_vec  (r_list),
        .o_idx  (w_low_idx),
        .o_zero (w_list_zero)
    );

    assign w_clr_mask = 16'd1 << w_low_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_list      <= 16'd0;
            r_cnt       <= 5'd0;
            r_addr      <= 32'd0;
            r_load      <= 1'b0;
            r_wb_en     <= 1'b0;
            r_base_code <= 4'd0;
            r_wb_data   <= 32'd0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_list  <= 16'd0;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_XFER;
                        r_list      <= i_reg_list;
                        r_cnt       <= w_pop;
                        r_addr      <= w_first_addr;
                        r_load      <= i_load;
                        r_wb_en     <= w_wb_en;
                        r_base_code <= i_base_code;
                        r_wb_data   <= w_wb_data;
                    end
                end
                ST_XFER: begin
                    if (i_mem_ready) begin
                        r_list <= r_list & ~w_clr_mask;
                        r_addr <= r_addr + XFER_STEP;
                        r_cnt  <= r_cnt - 5'd1;
                        if (r_cnt == 5'd1) begin
                            r_state <= r_wb_en ? ST_WB : ST_IDLE;
                        end
                    end
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_xfer_vld     = (r_state == ST_XFER) && !w_list_zero && !i_flush;
    assign o_xfer_addr    = r_addr;
    assign o_xfer_rd_code = w_low_idx;
    assign o_xfer_load    = r_load;
    assign o_xfer_last    = (r_cnt == 5'd1);
    assign o_wb_vld       = (r_state == ST_WB) && !i_flush;
    assign o_wb_code      = r_base_code;
    assign o_wb_data      = r_wb_data;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_ldm_hold     = w_start || (r_state != ST_IDLE);

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb/tb_ldm_stm_seq.sv - scoreboard bench for ldm_stm_seq
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        rst_n, start, up, pre, wb, load, flush, mem_ready;
    logic [15:0] reg_list;
    logic [31:0] base;
    logic [3:0]  base_code;

    logic        o_ldm_hold, o_xfer_vld, o_xfer_load, o_xfer_last, o_wb_vld, o_busy;
    logic [31:0] o_xfer_addr, o_wb_data;
    logic [3:0]  o_xfer_rd_code, o_wb_code;

    always #5 clk = ~clk;

    ldm_stm_seq dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_reg_list     (reg_list),
        .i_base         (base),
        .i_base_code    (base_code),
        .i_up           (up),
        .i_pre          (pre),
        .i_wb           (wb),
        .i_load         (load),
        .i_flush        (flush),
        .i_mem_ready    (mem_ready),
        .o_ldm_hold     (o_ldm_hold),
        .o_xfer_vld     (o_xfer_vld),
        .o_xfer_addr    (o_xfer_addr),
        .o_xfer_rd_code (o_xfer_rd_code),
        .o_xfer_load    (o_xfer_load),
        .o_xfer_last    (o_xfer_last),
        .o_wb_vld       (o_wb_vld),
        .o_wb_code      (o_wb_code),
        .o_wb_data      (o_wb_data),
        .o_busy         (o_busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  code;
        logic        load;
        logic        last;
    } xfer_t;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] data;
    } wbx_t;

    xfer_t exp_x[$];
    wbx_t  exp_w[$];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference: block occupies [lowest, lowest+4n), registers ascending.
    task automatic model(input logic [15:0] l, input logic [31:0] b, input logic [3:0] c,
                         input logic u, input logic p, input logic w, input logic ld);
        int          n;
        int          k;
        logic [31:0] lo;
        xfer_t       t;
        wbx_t        e;
        n = $countones(l);
        k = 0;
        if (n == 0) return;
        if (u) lo = p ? b + 32'd4 : b;
        else   lo = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
        for (int r = 0; r < 16; r++) begin
            if (l[r]) begin
                t.addr = lo + 32'(4 * k);
                t.code = 4'(r);
                t.load = ld;
                t.last = (k == n - 1);
                exp_x.push_back(t);
                k++;
            end
        end
        if (w && !(ld && l[c])) begin
            e.code = c;
            e.data = u ? b + 32'(4 * n) : b - 32'(4 * n);
            exp_w.push_back(e);
        end
    endtask

    xfer_t       mx;
    wbx_t        mw;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = 32'd0;
    logic [3:0]  prev_code  = 4'd0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        if (flush) begin
            chk("flush_xfer_vld", 32'(o_xfer_vld), 32'd0);
            chk("flush_wb_vld",   32'(o_wb_vld),   32'd0);
        end
        if (o_xfer_vld && prev_stall) begin
            chk("stall_addr", o_xfer_addr, prev_addr);
            chk("stall_code", 32'(o_xfer_rd_code), 32'(prev_code));
            chk("stall_last", 32'(o_xfer_last), 32'(prev_last));
        end
        if (o_xfer_vld && mem_ready) begin
            if (exp_x.size() == 0) begin
                chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                mx = exp_x.pop_front();
                chk("xfer_addr", o_xfer_addr, mx.addr);
                chk("xfer_code", 32'(o_xfer_rd_code), 32'(mx.code));
                chk("xfer_load", 32'(o_xfer_load), 32'(mx.load));
                chk("xfer_last", 32'(o_xfer_last), 32'(mx.last));
            end
        end
        if (o_wb_vld) begin
            if (exp_w.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                mw = exp_w.pop_front();
                chk("wb_code", 32'(o_wb_code), 32'(mw.code));
                chk("wb_data", o_wb_data, mw.data);
            end
        end
        prev_stall = o_xfer_vld && !mem_ready;
        prev_addr  = o_xfer_addr;
        prev_code  = o_xfer_rd_code;
        prev_last  = o_xfer_last;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},     32'(o_ldm_hold),     32'd0);
        chk({tag, "_xfer_vld"}, 32'(o_xfer_vld),     32'd0);
        chk({tag, "_addr"},     o_xfer_addr,         32'd0);
        chk({tag, "_rd_code"},  32'(o_xfer_rd_code), 32'd0);
        chk({tag, "_load"},     32'(o_xfer_load),    32'd0);
        chk({tag, "_last"},     32'(o_xfer_last),    32'd0);
        chk({tag, "_wb_vld"},   32'(o_wb_vld),       32'd0);
        chk({tag, "_wb_code"},  32'(o_wb_code),      32'd0);
        chk({tag, "_wb_data"},  o_wb_data,           32'd0);
        chk({tag, "_busy"},     32'(o_busy),         32'd0);
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready low for 3 cycles first
    task automatic run_seq(input logic [15:0] l, input logic [31:0] b, input logic [3:0] c,
                           input logic u, input logic p, input logic w, input logic ld,
                           input int mode, input bit noise);
        int cyc;
        int holds;
        int nexp;
        cyc   = 0;
        holds = 0;
        @(posedge clk);
        #1;
        reg_list = l; base = b; base_code = c;
        up = u; pre = p; wb = w; load = ld;
        start = 1'b1; mem_ready = 1'b0;
        model(l, b, c, u, p, w, ld);
        nexp = (l == 16'd0) ? 0 : $countones(l) + ((w && !(ld && l[c])) ? 1 : 0);
        #1;
        chk("hold_on_start", 32'(o_ldm_hold), 32'(l != 16'd0));
        @(posedge clk);
        #1;
        start = 1'b0;
        while (o_busy && cyc < 200) begin
            if (o_ldm_hold) holds++;
            if (mode == 0)      mem_ready = 1'b1;
            else if (mode == 2) mem_ready = (cyc >= 3);
            else                mem_ready = ($urandom_range(0, 3) != 0);
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                reg_list  = 16'($urandom);
                base      = $urandom;
                base_code = 4'($urandom);
                up        = 1'($urandom);
                load      = 1'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        mem_ready = 1'b0;
        chk("seq_timeout", 32'(cyc >= 200), 32'd0);
        if (mode == 0 && !noise) chk("hold_cycles", 32'(holds), 32'(nexp));
        chk("xfer_queue_drained", 32'(exp_x.size()), 32'd0);
        chk("wb_queue_drained",   32'(exp_w.size()), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; up = 1'b0; pre = 1'b0; wb = 1'b0; load = 1'b0;
        flush = 1'b0; mem_ready = 1'b0; reg_list = 16'd0; base = 32'd0; base_code = 4'd0;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_seq(16'h000F, 32'h0000_1000, 4'd13, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_seq(16'h8001, 32'h0000_2000, 4'd13, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_seq(16'h0006, 32'h0000_1000, 4'd13, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        run_seq(16'h0011, 32'h0000_3000, 4'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        run_seq(16'hFFFF, 32'hFFFF_FFF0, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        run_seq(16'h0000, 32'h0000_5000, 4'd1,  1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run_seq(16'h0300, 32'h0000_0004, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

        // Flush while the second of four transfers is presented.
        @(posedge clk);
        #1;
        reg_list = 16'h000F; base = 32'h0000_6000; base_code = 4'd9;
        up = 1'b1; pre = 1'b0; wb = 1'b1; load = 1'b0; start = 1'b1; mem_ready = 1'b1;
        model(16'h000F, 32'h0000_6000, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b1;
        chk("flush_pending_xfers", 32'(exp_x.size()), 32'd3);
        @(posedge clk);
        #1;
        flush = 1'b0;
        mem_ready = 1'b0;
        chk("flush_idle_busy", 32'(o_busy), 32'd0);
        chk("flush_idle_hold", 32'(o_ldm_hold), 32'd0);
        exp_x.delete();
        exp_w.delete();
        repeat (4) @(posedge clk);

        // Asynchronous reset in the middle of a stalled transfer.
        #1;
        reg_list = 16'h00F0; base = 32'h0000_4000; base_code = 4'd3;
        up = 1'b1; pre = 1'b0; wb = 1'b1; load = 1'b1; start = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("pre_reset_xfer_vld", 32'(o_xfer_vld), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(o_busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] l;
            l = 16'($urandom);
            if (i % 8 == 0) l = 16'hFFFF;
            if (i % 8 == 1) l = 16'h0000;
            run_seq(l, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 1, 1'b1);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
